// File: rtl/fma16_pkg.sv
// Shared opcode, rounding-mode and control types for the fma16 issue path.
package fma16_pkg;

    typedef enum logic [2:0] {
        FADD       = 3'b000,
        FSUB       = 3'b001,
        FMUL       = 3'b010,
        FMADD      = 3'b011,
        FMSUB      = 3'b100,
        FNMADD     = 3'b101,
        FNMSUB     = 3'b110,
        OP_ILLEGAL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        RZ  = 2'b00,
        RNE = 2'b01,
        RP  = 2'b10,
        RN  = 2'b11
    } rm_e;

    typedef struct packed {
        logic mul;
        logic add;
        logic negr;
        logic negz;
    } fma_ctrl_t;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/fma16_issue_if.sv
// Request, fma16 operand/result and response bundle; slave is the issue stage side.
interface fma16_issue_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [15:0]      req_x;
    logic [15:0]      req_y;
    logic [15:0]      req_z;
    logic [1:0]       req_rm;
    logic [TAG_W-1:0] req_tag;

    logic [15:0]      fma_x;
    logic [15:0]      fma_y;
    logic [15:0]      fma_z;
    logic             fma_mul;
    logic             fma_add;
    logic             fma_negr;
    logic             fma_negz;
    logic [1:0]       fma_roundmode;
    logic [15:0]      fma_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_result;
    logic             rsp_illegal;
    logic [TAG_W-1:0] rsp_tag;

    modport slave (
        input  req_valid, req_op, req_x, req_y, req_z, req_rm, req_tag,
        output req_ready,
        output fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negr, fma_negz, fma_roundmode,
        input  fma_result,
        output rsp_valid, rsp_result, rsp_illegal, rsp_tag,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_x, req_y, req_z, req_rm, req_tag,
        input  req_ready,
        input  fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negr, fma_negz, fma_roundmode,
        output fma_result,
        input  rsp_valid, rsp_result, rsp_illegal, rsp_tag,
        output rsp_ready
    );

endinterface

// File: rtl/fma16_op_decode.sv
// Opcode to fma16 {mul,add,negr,negz} decode; combinational, no backpressure.
module fma16_op_decode
    import fma16_pkg::*;
(
    input  op_e       op_i,
    output fma_ctrl_t ctrl_o,
    output logic      illegal_o
);

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        case (op_i)
            FADD:    ctrl_o = 4'b0100;
            FSUB:    ctrl_o = 4'b0101;
            FMUL:    ctrl_o = 4'b1000;
            FMADD:   ctrl_o = 4'b1100;
            FMSUB:   ctrl_o = 4'b1101;
            FNMADD:  ctrl_o = 4'b1110;
            FNMSUB:  ctrl_o = 4'b1111;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fma16_issue.sv
// Issue/capture stage for fma16: legal ops respond EXEC_CYCLES after accept, illegal after 1.
// Holds the response while rsp_ready is low; req_ready reopens in DONE when the response retires.
module fma16_issue
    import fma16_pkg::*;
#(
    parameter int EXEC_CYCLES = 2,
    parameter int TAG_W       = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    fma16_issue_if.slave  bus,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic [15:0]      fma_x_q, fma_y_q, fma_z_q;
    fma_ctrl_t        ctrl_q;
    rm_e              rm_q;
    logic [TAG_W-1:0] tag_q;
    logic [15:0]      rsp_result_q;
    logic             rsp_illegal_q;
    logic [TAG_W-1:0] rsp_tag_q;

    op_e       req_op;
    fma_ctrl_t dec_ctrl;
    logic      dec_illegal;
    logic      accept;

    assign req_op = op_e'(bus.req_op);

    fma16_op_decode u_dec (
        .op_i      (req_op),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    assign bus.req_ready = (state_q == IDLE) || ((state_q == DONE) && bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            fma_x_q       <= '0;
            fma_y_q       <= '0;
            fma_z_q       <= '0;
            ctrl_q        <= '0;
            rm_q          <= RZ;
            tag_q         <= '0;
            rsp_result_q  <= '0;
            rsp_illegal_q <= 1'b0;
            rsp_tag_q     <= '0;
        end else if (accept) begin
            // Illegal ops bypass fma16 entirely so the operand registers keep the last legal op.
            if (dec_illegal) begin
                rsp_result_q  <= FP16_QNAN;
                rsp_illegal_q <= 1'b1;
                rsp_tag_q     <= bus.req_tag;
                state_q       <= DONE;
            end else begin
                fma_x_q <= bus.req_x;
                fma_y_q <= bus.req_y;
                fma_z_q <= bus.req_z;
                ctrl_q  <= dec_ctrl;
                rm_q    <= rm_e'(bus.req_rm);
                tag_q   <= bus.req_tag;
                cnt_q   <= 4'(EXEC_CYCLES - 1);
                state_q <= EXEC;
            end
        end else begin
            case (state_q)
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        rsp_result_q  <= bus.fma_result;
                        rsp_illegal_q <= 1'b0;
                        rsp_tag_q     <= tag_q;
                        state_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fma_x         = fma_x_q;
    assign bus.fma_y         = fma_y_q;
    assign bus.fma_z         = fma_z_q;
    assign bus.fma_mul       = ctrl_q.mul;
    assign bus.fma_add       = ctrl_q.add;
    assign bus.fma_negr      = ctrl_q.negr;
    assign bus.fma_negz      = ctrl_q.negz;
    assign bus.fma_roundmode = rm_q;
    assign bus.rsp_valid     = (state_q == DONE);
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_illegal   = rsp_illegal_q;
    assign bus.rsp_tag       = rsp_tag_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_fma16_issue.sv
// Directed bench for fma16_issue: EXEC_CYCLES=2 instance for function/backpressure/reset, EXEC_CYCLES=1 for streaming.
module tb_fma16_issue;

    logic clk = 1'b0;
    logic reset_n;
    logic busy2, busy1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fma16_issue_if #(.TAG_W(4)) bus2 ();
    fma16_issue_if #(.TAG_W(4)) bus1 ();

    fma16_issue #(.EXEC_CYCLES(2), .TAG_W(4)) dut2 (
        .clk (clk), .reset_n (reset_n), .bus (bus2), .busy (busy2)
    );
    fma16_issue #(.EXEC_CYCLES(1), .TAG_W(4)) dut1 (
        .clk (clk), .reset_n (reset_n), .bus (bus1), .busy (busy1)
    );

    // Integer-add stub stands in for fma16 on the streaming instance.
    assign bus1.fma_result = bus1.fma_x + bus1.fma_y;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ctrl2();
        return {bus2.fma_mul, bus2.fma_add, bus2.fma_negr, bus2.fma_negz};
    endfunction

    task automatic drive2(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] z, input logic [1:0] rm, input logic [3:0] tag);
        bus2.req_op  = op;
        bus2.req_x   = x;
        bus2.req_y   = y;
        bus2.req_z   = z;
        bus2.req_rm  = rm;
        bus2.req_tag = tag;
    endtask

    initial begin
        int idx, rsp_cnt, last_cyc;
        logic acc;

        reset_n = 1'b0;
        bus2.req_valid = 0; bus2.rsp_ready = 0; bus2.fma_result = 16'h0;
        drive2(3'b000, 16'h0, 16'h0, 16'h0, 2'b00, 4'h0);
        bus1.req_valid = 0; bus1.rsp_ready = 1;
        bus1.req_op = 3'b000; bus1.req_x = 0; bus1.req_y = 0; bus1.req_z = 0;
        bus1.req_rm = 2'b01; bus1.req_tag = 0;
        tick(); tick();

        check("rst_rsp_valid", 32'(bus2.rsp_valid), 0);
        check("rst_busy", 32'(busy2), 0);
        check("rst_fma_x", 32'(bus2.fma_x), 0);
        check("rst_ctrl", 32'(ctrl2()), 0);
        check("rst_rsp_result", 32'(bus2.rsp_result), 0);
        reset_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(bus2.req_ready), 1);

        // fmul 1.0 * 2.0
        bus2.fma_result = 16'h4000;
        drive2(3'b010, 16'h3C00, 16'h4000, 16'h0000, 2'b01, 4'd5);
        bus2.req_valid = 1;
        tick();
        bus2.req_valid = 0;
        check("fmul_ctrl", 32'(ctrl2()), 32'h8);
        check("fmul_rm", 32'(bus2.fma_roundmode), 1);
        check("fmul_fma_y", 32'(bus2.fma_y), 32'h4000);
        check("fmul_busy", 32'(busy2), 1);
        check("fmul_valid_k0", 32'(bus2.rsp_valid), 0);
        tick();
        check("fmul_valid_k1", 32'(bus2.rsp_valid), 0);
        tick();
        check("fmul_valid_k2", 32'(bus2.rsp_valid), 1);
        check("fmul_result", 32'(bus2.rsp_result), 32'h4000);
        check("fmul_tag", 32'(bus2.rsp_tag), 5);
        check("fmul_illegal", 32'(bus2.rsp_illegal), 0);
        bus2.rsp_ready = 1;
        tick();
        bus2.rsp_ready = 0;
        check("fmul_retire", 32'(bus2.rsp_valid), 0);

        // fnmsub with operand hold while req_x churns
        bus2.fma_result = 16'hC200;
        drive2(3'b110, 16'h3C00, 16'h3C00, 16'h4200, 2'b00, 4'd3);
        bus2.req_valid = 1;
        tick();
        bus2.req_valid = 0;
        check("fnmsub_ctrl", 32'(ctrl2()), 32'hF);
        for (int i = 0; i < 2; i++) begin
            bus2.req_x = 16'($urandom);
            bus2.req_z = 16'($urandom);
            check("fnmsub_hold_x", 32'(bus2.fma_x), 32'h3C00);
            check("fnmsub_hold_z", 32'(bus2.fma_z), 32'h4200);
            tick();
        end
        check("fnmsub_valid", 32'(bus2.rsp_valid), 1);
        check("fnmsub_result", 32'(bus2.rsp_result), 32'hC200);
        check("fnmsub_done_hold_x", 32'(bus2.fma_x), 32'h3C00);
        bus2.rsp_ready = 1;
        tick();
        bus2.rsp_ready = 0;

        // Illegal opcode from IDLE
        drive2(3'b111, 16'h1111, 16'h2222, 16'h3333, 2'b10, 4'd9);
        bus2.req_valid = 1;
        tick();
        bus2.req_valid = 0;
        check("ill_valid", 32'(bus2.rsp_valid), 1);
        check("ill_result", 32'(bus2.rsp_result), 32'h7E00);
        check("ill_flag", 32'(bus2.rsp_illegal), 1);
        check("ill_tag", 32'(bus2.rsp_tag), 9);
        check("ill_fma_x", 32'(bus2.fma_x), 32'h3C00);
        check("ill_ctrl", 32'(ctrl2()), 32'hF);

        // Backpressure in DONE with a pending request
        drive2(3'b000, 16'h4000, 16'h3C00, 16'h0, 2'b01, 4'd7);
        bus2.req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            check("bp_req_ready", 32'(bus2.req_ready), 0);
            check("bp_valid", 32'(bus2.rsp_valid), 1);
            check("bp_result", 32'(bus2.rsp_result), 32'h7E00);
            check("bp_tag", 32'(bus2.rsp_tag), 9);
            tick();
        end
        bus2.rsp_ready = 1;
        #1;
        check("bp_release_ready", 32'(bus2.req_ready), 1);
        tick();
        bus2.req_valid = 0;
        check("same_edge_valid", 32'(bus2.rsp_valid), 0);
        check("same_edge_busy", 32'(busy2), 1);
        check("same_edge_ctrl", 32'(ctrl2()), 32'h4);
        check("same_edge_fma_x", 32'(bus2.fma_x), 32'h4000);

        // Reset while the fadd is still in EXEC
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy2), 0);
        check("mid_rst_valid", 32'(bus2.rsp_valid), 0);
        check("mid_rst_fma_x", 32'(bus2.fma_x), 0);
        check("mid_rst_ctrl", 32'(ctrl2()), 0);
        check("mid_rst_tag", 32'(bus2.rsp_tag), 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_valid", 32'(bus2.rsp_valid), 0);
            check("post_rst_ready", 32'(bus2.req_ready), 1);
        end

        // Streaming fadd on the EXEC_CYCLES=1 instance
        idx = 0; rsp_cnt = 0; last_cyc = 0;
        bus1.req_x = 16'h0101; bus1.req_y = 16'h0000; bus1.req_tag = 4'd0;
        bus1.req_valid = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = bus1.req_valid && bus1.req_ready;
            tick();
            if (bus1.rsp_valid) begin
                check("stream_tag", 32'(bus1.rsp_tag), 32'(rsp_cnt));
                check("stream_result", 32'(bus1.rsp_result),
                      32'(16'h0101 * rsp_cnt + 16'h0101 + 16'h0010 * rsp_cnt));
                if (rsp_cnt > 0) check("stream_gap", 32'(cyc - last_cyc), 2);
                last_cyc = cyc;
                rsp_cnt++;
            end
            if (acc) begin
                idx++;
                if (idx == 8) begin
                    bus1.req_valid = 0;
                end else begin
                    bus1.req_x   = 16'(16'h0101 * idx + 16'h0101);
                    bus1.req_y   = 16'(16'h0010 * idx);
                    bus1.req_tag = 4'(idx);
                end
            end
        end
        check("stream_count", 32'(rsp_cnt), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
